// File: rtl/generador_pwm.sv
// PWM generator with 2047-clock period and double-buffered duty load (pending -> active at period wrap).
// Optional complementary output PWM_Out_N when PWM_COMPLEMENTARIO_EN is defined.
module generador_pwm (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [10:0] Dato_In,
    input  logic        CS,
    input  logic        En,
    output logic        PWM_Out,
    output logic        Fin_Periodo,
    output logic        Dato_Ack,
`ifdef PWM_COMPLEMENTARIO_EN
    output logic        PWM_Out_N,
`endif
    output logic        Sobrecarga
);

    localparam logic [10:0] CUENTA_MAX = 11'd2046;

    typedef enum logic {IDLE, RUN} estado_t;

    estado_t     estado;
    logic        cs_prev;
    logic [10:0] pendiente;
    logic        flag_pend;
    logic [10:0] activo;
    logic [10:0] contador;

    logic cs_flanco;
    logic en_marcha;
    logic envoltura;
    logic transferencia;
    logic aplicar;
    logic pwm_nxt;

    assign cs_flanco     = CS & ~cs_prev;
    assign en_marcha     = (estado == RUN) & En;
    assign envoltura     = en_marcha & (contador == CUENTA_MAX);
    // Entering RUN loads the newest duty just like a wrap, so the first period is never stale.
    assign transferencia = ((estado == IDLE) & En) | envoltura;
    assign aplicar       = transferencia & flag_pend;
    assign pwm_nxt       = en_marcha & (contador < activo);

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            estado      <= IDLE;
            cs_prev     <= 1'b0;
            pendiente   <= '0;
            flag_pend   <= 1'b0;
            activo      <= '0;
            contador    <= '0;
            PWM_Out     <= 1'b0;
            Fin_Periodo <= 1'b0;
            Dato_Ack    <= 1'b0;
            Sobrecarga  <= 1'b0;
        end else begin
            cs_prev     <= CS;
            estado      <= En ? RUN : IDLE;
            PWM_Out     <= pwm_nxt;
            Fin_Periodo <= envoltura;
            Dato_Ack    <= aplicar;

            if (en_marcha && !envoltura) begin
                contador <= contador + 11'd1;
            end else begin
                contador <= '0;
            end

            if (aplicar) begin
                activo    <= pendiente;
                flag_pend <= 1'b0;
            end

            // A load arriving on the transfer edge stays pending; the later write wins over the clear.
            if (cs_flanco) begin
                pendiente <= Dato_In;
                flag_pend <= 1'b1;
                if (flag_pend && !aplicar) begin
                    Sobrecarga <= 1'b1;
                end
            end
        end
    end

`ifdef PWM_COMPLEMENTARIO_EN
    // High on the IDLE->RUN edge too, so it is the inverse of PWM_Out from the first RUN cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            PWM_Out_N <= 1'b0;
        end else begin
            PWM_Out_N <= En & ~pwm_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_generador_pwm.sv
// Directed self-checking bench for generador_pwm: duty load, wrap transfer, overrun, coincident load,
// idle/reset behaviour and (when PWM_COMPLEMENTARIO_EN is defined) the complementary output.
module tb_generador_pwm;

    logic        clk;
    logic        reset_n;
    logic [10:0] Dato_In;
    logic        CS;
    logic        En;
    logic        PWM_Out;
    logic        Fin_Periodo;
    logic        Dato_Ack;
    logic        Sobrecarga;
`ifdef PWM_COMPLEMENTARIO_EN
    logic        PWM_Out_N;
`endif

    int checks = 0;
    int errors = 0;
    int inv_err = 0;

    generador_pwm dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .Dato_In     (Dato_In),
        .CS          (CS),
        .En          (En),
        .PWM_Out     (PWM_Out),
        .Fin_Periodo (Fin_Periodo),
        .Dato_Ack    (Dato_Ack),
`ifdef PWM_COMPLEMENTARIO_EN
        .PWM_Out_N   (PWM_Out_N),
`endif
        .Sobrecarga  (Sobrecarga)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_inv();
`ifdef PWM_COMPLEMENTARIO_EN
        if (PWM_Out_N !== ~PWM_Out) inv_err++;
`endif
    endtask

    task automatic check_idle_n(input string tag);
`ifdef PWM_COMPLEMENTARIO_EN
        check(tag, int'(PWM_Out_N), 0);
`endif
    endtask

    // Steps until Fin_Periodo is seen; counts the current sample as step 0.
    task automatic wait_fin(input int budget, output int waited, output int high, output int acks);
        waited = 0;
        high   = 0;
        acks   = 0;
        check_inv();
        while (!Fin_Periodo && waited < budget) begin
            step();
            waited++;
            if (PWM_Out) high++;
            if (Dato_Ack) acks++;
            check_inv();
        end
    endtask

    // Observes the 2047 samples following a Fin_Periodo cycle (counter values 1..2046 then 0),
    // optionally issuing up to two CS loads at given sample indexes.
    task automatic run_period(input int at1, input int v1, input int at2, input int v2,
                              output int high, output int segs, output int fin_bad,
                              output int ack_end, output int ack_mid);
        logic prev;
        prev    = 1'b0;
        high    = 0;
        segs    = 0;
        fin_bad = 0;
        ack_end = 0;
        ack_mid = 0;
        for (int i = 1; i <= 2047; i++) begin
            step();
            if (PWM_Out) high++;
            if (PWM_Out && !prev) segs++;
            prev = PWM_Out;
            if (i < 2047 && Fin_Periodo) fin_bad++;
            if (i == 2047 && !Fin_Periodo) fin_bad++;
            if (i == 2047) ack_end = int'(Dato_Ack);
            else if (Dato_Ack) ack_mid++;
            check_inv();
            if (i == at1 || i == at2) begin
                Dato_In = (i == at1) ? v1[10:0] : v2[10:0];
                CS      = 1'b1;
            end else if (i == at1 + 1 || i == at2 + 1) begin
                CS      = 1'b0;
            end
        end
    endtask

    task automatic period_chk(input string tag, input int at1, input int v1, input int at2, input int v2,
                              input int exp_high, input int exp_ack);
        int high, segs, fin_bad, ack_end, ack_mid;
        run_period(at1, v1, at2, v2, high, segs, fin_bad, ack_end, ack_mid);
        check({tag, "_high"}, high, exp_high);
        check({tag, "_segs"}, segs, (exp_high == 0) ? 0 : 1);
        check({tag, "_fin"}, fin_bad, 0);
        check({tag, "_ack_end"}, ack_end, exp_ack);
        check({tag, "_ack_mid"}, ack_mid, 0);
    endtask

    initial begin
        int waited, high, acks;
        reset_n = 1'b0;
        Dato_In = '0;
        CS      = 1'b0;
        En      = 1'b0;
        repeat (3) step();
        check("rst_pwm", int'(PWM_Out), 0);
        check("rst_fin", int'(Fin_Periodo), 0);
        check("rst_ack", int'(Dato_Ack), 0);
        check("rst_sob", int'(Sobrecarga), 0);
        check_idle_n("rst_pwm_n");
        reset_n = 1'b1;
        step();

        // Load 1024 while idle, then start.
        Dato_In = 11'd1024;
        CS = 1'b1;
        step();
        CS = 1'b0;
        step();
        check("idle_ack", int'(Dato_Ack), 0);
        check("idle_pwm", int'(PWM_Out), 0);
        check_idle_n("idle_pwm_n");
        En = 1'b1;
        step();
        check("start_ack", int'(Dato_Ack), 1);
        wait_fin(2100, waited, high, acks);
        check("first_period_len", waited, 2047);
        check("first_period_high", high, 1024);
        check("first_period_acks", acks, 0);
        period_chk("p1024_a", -10, 0, -10, 0, 1024, 0);
        period_chk("p1024_b", -10, 0, -10, 0, 1024, 0);

        // Mid-period load of 2047: current period unchanged, next constantly high.
        period_chk("load2047", 500, 2047, -10, 0, 1024, 1);
        period_chk("p2047", -10, 0, -10, 0, 2047, 0);

        // Load coinciding with the wrap edge stays pending one more period.
        period_chk("coinc", 2046, 500, -10, 0, 2047, 0);
        check("coinc_sob", int'(Sobrecarga), 0);
        period_chk("coinc_keep", -10, 0, -10, 0, 2047, 1);
        check("coinc_sob2", int'(Sobrecarga), 0);
        period_chk("p500", -10, 0, -10, 0, 500, 0);

        // Two loads in one period: overrun flagged, last value wins.
        period_chk("overrun", 100, 100, 700, 300, 500, 1);
        check("overrun_sob", int'(Sobrecarga), 1);
        period_chk("p300", 10, 0, -10, 0, 300, 1);

        // Duty 0, then drop En mid-period.
        high = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (PWM_Out) high++;
            check_inv();
        end
        check("duty0_high", high, 0);
        En = 1'b0;
        step();
        check("en0_contador", int'(dut.contador), 0);
        check("en0_pwm", int'(PWM_Out), 0);
        check("en0_fin", int'(Fin_Periodo), 0);
        check_idle_n("en0_pwm_n");
        step();
        check("sob_sticky", int'(Sobrecarga), 1);
        check_idle_n("idle2_pwm_n");

        // Restart with duty 0, load 700 mid-period, then reset before it is applied.
        En = 1'b1;
        step();
        check("restart_ack", int'(Dato_Ack), 0);
        high = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (PWM_Out) high++;
            check_inv();
        end
        Dato_In = 11'd700;
        CS = 1'b1;
        step();
        CS = 1'b0;
        repeat (20) step();
        check("pre_rst_high", high + int'(PWM_Out), 0);
        #2 reset_n = 1'b0;
        #1;
        check("arst_pwm", int'(PWM_Out), 0);
        check("arst_fin", int'(Fin_Periodo), 0);
        check("arst_ack", int'(Dato_Ack), 0);
        check("arst_sob", int'(Sobrecarga), 0);
        check("arst_activo", int'(dut.activo), 0);
        check("arst_flag", int'(dut.flag_pend), 0);
        check_idle_n("arst_pwm_n");
        step();
        reset_n = 1'b1;
        high = 0;
        acks = 0;
        for (int i = 0; i < 2200; i++) begin
            step();
            if (PWM_Out) high++;
            if (Dato_Ack) acks++;
            check_inv();
        end
        check("post_rst_high", high, 0);
        check("post_rst_acks", acks, 0);
        check("post_rst_sob", int'(Sobrecarga), 0);
`ifdef PWM_COMPLEMENTARIO_EN
        // Duty 10 with the complementary output.
        En = 1'b0;
        step();
        Dato_In = 11'd10;
        CS = 1'b1;
        step();
        CS = 1'b0;
        En = 1'b1;
        step();
        wait_fin(2100, waited, high, acks);
        check("d10_high", high, 10);
`endif
        check("pwm_n_inverse", inv_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
